mux_arbiter: RTL
================

# mux_arbiter

Round-robin arbiter and sequencer for a shared dual 4-to-1 multiplexer (74LS153-style datapath). Up to four requesters share the mux outputs. The block drives the two select lines and the strobe/blanking input, and returns a one-hot grant. Select changes are break-before-make: the mux outputs are forced low while the select settles, so no requester ever sees another requester's data.

## Interface
Parameters:
- SETTLE, default 1: blanking cycles after a select change before the grant is issued; range 0..15.
- MAX_HOLD, default 16: cycles a grant may be held while another requester is pending; 0 disables the limit; range 0..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req  in  4  request per requester; held high for the whole access.
- gnt  out  4  one-hot grant; all-zero when no requester owns the mux.
- sel  out  2  mux select (A = sel[1], B = sel[0]); drives both sections.
- blank  out  1  mux strobe; 1 forces both mux outputs to 0.
- busy  out  1  high in SETTLE and GRANT.
- timeout  out  1  one-cycle pulse when a grant is forcibly revoked.

## Operation
- All outputs are registered.
- Reset values: gnt=0000, sel=00, blank=1, busy=0, timeout=0, state=IDLE, last winner pointer=3, so requester 0 has top priority first.
- States: IDLE, SETTLE, GRANT.
- IDLE:
  - Outputs: blank=1, gnt=0, busy=0; sel holds its previous value.
  - If req≠0, the winner is the first requester set in the order last+1, last+2, … mod 4.
  - On a win: sel←winner. Go to SETTLE with count=SETTLE, or straight to GRANT if SETTLE=0.
- SETTLE:
  - Outputs: blank=1, gnt=0, busy=1.
  - count decrements each cycle; go to GRANT when it reaches 0 (SETTLE cycles in total).
  - If req[sel] drops during SETTLE, go to IDLE. No grant is issued and the pointer is unchanged.
- GRANT:
  - Outputs: blank=0, gnt[sel]=1, busy=1. The hold counter starts at 0 and increments each cycle, saturating at 255.
  - Normal release: req[sel]=0 sampled → IDLE; last←sel.
  - Forced release: MAX_HOLD≠0, hold counter = MAX_HOLD−1, and any other req bit is set → IDLE; last←sel; timeout=1 for the following cycle only.
  - With no other requester pending, the grant is never revoked.
- Requests from non-granted requesters never change sel, gnt or blank during GRANT.
- IDLE always lasts at least one cycle between consecutive grants. gnt and blank=0 are therefore never asserted in adjacent cycles for different owners.
- A requester that re-asserts immediately after release waits behind all other pending requesters.

## Timing
- Request latency: req rises before edge 0 → edge 0 enters SETTLE with sel valid → gnt high after edge SETTLE. Total SETTLE+1 edges; 1 edge when SETTLE=0.
- blank falls on the same edge that gnt rises. gnt falls, and blank rises, on the edge after req is sampled low.
- Back-to-back handover (A releases, B pending), per-edge sequence:
  - GRANT(A) → IDLE → SETTLE(B) ×SETTLE → GRANT(B).
  - Gap with gnt=0: SETTLE+1 cycles.
- Forced release: gnt drops on the edge after the MAX_HOLD-th granted cycle. timeout is high for the one cycle following that edge.
- rst mid-operation: all outputs take their reset values immediately (asynchronously), including gnt=0 and blank=1. A requester still holding req re-arbitrates normally after rst falls.
- Simultaneous release and new request from the same requester in one cycle: release wins, and rotation applies.

## Test plan
- Reset, then req=0001 with SETTLE=1:
  - sel=00 after 1 edge, gnt=0001 and blank=0 after 2 edges.
  - Drop req → gnt=0000, blank=1 one edge later.
- req=1111 held, each owner dropping its req after 3 granted cycles:
  - Grant order 0,1,2,3,0.
  - Each handover shows 2 cycles of gnt=0 with blank=1.
- MAX_HOLD=4, req0 held forever, req2 raised:
  - gnt0 lasts exactly 4 cycles, timeout pulses for 1 cycle, then gnt=0100.
  - With only req0 high, no timeout occurs after 100 cycles.
- SETTLE=3, req1 raised then dropped after 2 cycles:
  - No grant is issued, blank stays 1, return to IDLE.
  - A subsequent req1 is granted after 4 edges.
- rst asserted mid-GRANT with req=0010:
  - gnt=0000, blank=1, sel=00 without waiting for a clock edge.
  - After release, gnt=0010 two edges later.
- SETTLE=0, req=0101:
  - gnt=0001 one edge after request.
  - After release, gnt=0100 with exactly 1 idle cycle between.

Source files
------------

// File: rtl/mux_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mux_arbiter
//  Purpose  : Round-robin arbiter and sequencer for a shared dual 4-to-1 mux
//             (74LS153-style datapath). Up to four requesters share the mux.
//             The block drives the mux select and strobe (blanking) lines and
//             returns a one-hot grant. Every select change is break-before-
//             make: the mux outputs stay blanked while the select settles.
//  Ports    : clk      in   system clock, rising edge
//             rst      in   asynchronous reset, active-high
//             req[3:0] in   per-requester request, held for the whole access
//             gnt[3:0] out  one-hot grant, zero when the mux is unowned
//             sel[1:0] out  mux select (A = sel[1], B = sel[0])
//             blank    out  mux strobe, 1 forces both mux outputs low
//             busy     out  high while settling or granted
//             timeout  out  one-cycle pulse after a forced revocation
//  Params   : SETTLE   blanking cycles after a select change (0..15)
//             MAX_HOLD granted cycles allowed while others wait, 0 = no limit
//  Revision : 1.0 - initial release
// ============================================================================
module mux_arbiter #(
    parameter int SETTLE   = 1,
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    output logic [3:0] gnt,
    output logic [1:0] sel,
    output logic       blank,
    output logic       busy,
    output logic       timeout
);

    localparam logic [1:0] c_st_idle   = 2'd0;
    localparam logic [1:0] c_st_settle = 2'd1;
    localparam logic [1:0] c_st_grant  = 2'd2;

    localparam logic [3:0] c_settle_cnt = 4'(SETTLE);
    localparam logic       c_hold_en    = (MAX_HOLD != 0);
    // Value the hold counter shows during the last permitted granted cycle.
    localparam logic [7:0] c_hold_last  = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

    logic [1:0] r_state;
    logic [1:0] r_sel;
    logic [1:0] r_last;
    logic [3:0] r_count;
    logic [7:0] r_hold;
    logic [3:0] r_gnt;
    logic       r_blank;
    logic       r_busy;
    logic       r_timeout;

    logic [1:0] w_win;
    logic [1:0] w_idx;
    logic       w_found;
    logic [3:0] w_sel_onehot;
    logic [3:0] w_win_onehot;
    logic       w_own_req;
    logic       w_others;

    // Round-robin search starting just after the last owner; offset 4 wraps
    // back to the last owner itself, so it has the lowest priority.
    always_comb begin
        w_win   = r_last;
        w_found = 1'b0;
        w_idx   = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            w_idx = r_last + 2'(i);
            if (!w_found && req[w_idx]) begin
                w_win   = w_idx;
                w_found = 1'b1;
            end
        end
    end

    assign w_sel_onehot = 4'b0001 << r_sel;
    assign w_win_onehot = 4'b0001 << w_win;
    assign w_own_req    = req[r_sel];
    assign w_others     = |(req & ~w_sel_onehot);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_st_idle;
            r_sel     <= 2'd0;
            r_last    <= 2'd3;
            r_count   <= 4'd0;
            r_hold    <= 8'd0;
            r_gnt     <= 4'b0000;
            r_blank   <= 1'b1;
            r_busy    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (|req) begin
                        r_sel  <= w_win;
                        r_busy <= 1'b1;
                        if (SETTLE == 0) begin
                            r_state <= c_st_grant;
                            r_gnt   <= w_win_onehot;
                            r_blank <= 1'b0;
                            r_hold  <= 8'd0;
                        end else begin
                            r_state <= c_st_settle;
                            r_count <= c_settle_cnt;
                        end
                    end
                end

                c_st_settle: begin
                    // Requester gave up before the grant: abandon quietly,
                    // the rotation pointer is left untouched.
                    if (!w_own_req) begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                    end else if (r_count == 4'd1) begin
                        r_state <= c_st_grant;
                        r_gnt   <= w_sel_onehot;
                        r_blank <= 1'b0;
                        r_hold  <= 8'd0;
                    end else begin
                        r_count <= r_count - 4'd1;
                    end
                end

                c_st_grant: begin
                    if (!w_own_req ||
                        (c_hold_en && (r_hold == c_hold_last) && w_others)) begin
                        r_state   <= c_st_idle;
                        r_gnt     <= 4'b0000;
                        r_blank   <= 1'b1;
                        r_busy    <= 1'b0;
                        r_last    <= r_sel;
                        r_timeout <= w_own_req;
                    end else if (r_hold != 8'hff) begin
                        r_hold <= r_hold + 8'd1;
                    end
                end

                default: begin
                    r_state <= c_st_idle;
                    r_gnt   <= 4'b0000;
                    r_blank <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = r_gnt;
    assign sel     = r_sel;
    assign blank   = r_blank;
    assign busy    = r_busy;
    assign timeout = r_timeout;

endmodule
`default_nettype wire
